// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state type and timing constant for the SAR ADC model
`timescale 1ns/1ps
package sar_pkg;

    typedef enum logic [1:0] {
        SAR_IDLE = 2'd0,
        SAR_CONV = 2'd1,
        SAR_DONE = 2'd2
    } sar_state_e;

    localparam int unsigned SAR_CLK_PERIOD_NS = 10;

endpackage

// File: rtl/sar_trial_dac.sv
// rtl/sar_trial_dac.sv - ideal trial DAC: converts the SAR trial code into a comparator threshold
`timescale 1ns/1ps
module sar_trial_dac #(
    parameter int  NBITS = 8,
    parameter real VMIN  = 0.0,
    parameter real VREF  = 1.0
) (
    input  logic [NBITS-1:0] code,
    output real              vth
);

    // Swap this module for a gain/offset-error model without touching the SAR loop.
    localparam real LSB = (VREF - VMIN) / real'(64'd1 << NBITS);

    assign vth = VMIN + real'(code) * LSB;

endmodule

// File: rtl/sar_adc_wr.sv
// rtl/sar_adc_wr.sv - behavioural SAR ADC: sample on START, resolve MSB-first, strobe DONE
`timescale 1ns/1ps
module sar_adc_wr
    import sar_pkg::*;
#(
    parameter int  NBITS = 8,
    parameter real VMIN  = 0.0,
    parameter real VREF  = 1.0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  real              AIN,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [NBITS-1:0] DOUT,
    output logic             OVR
);

    localparam int              IW  = $clog2(NBITS);
    localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_e       state_q, state_d;
    real              hold_q, hold_d;
    logic [NBITS-1:0] trial_q, trial_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             lo_q, lo_d;
    logic             hi_q, hi_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             ovr_q, ovr_d;
    logic [NBITS-1:0] resolved;
    real              vth;

    sar_trial_dac #(
        .NBITS (NBITS),
        .VMIN  (VMIN),
        .VREF  (VREF)
    ) u_dac (
        .code (trial_q),
        .vth  (vth)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dout_d   = dout_q;
        ovr_d    = ovr_q;
        resolved = trial_q;

        case (state_q)
            SAR_IDLE, SAR_DONE: begin
                state_d = SAR_IDLE;
                if (START) begin
                    state_d = SAR_CONV;
                    hold_d  = AIN;
                    trial_d = MSB;
                    idx_d   = IW'(NBITS - 1);
                    lo_d    = (AIN < VMIN);
                    hi_d    = (AIN >= VREF);
                end
            end
            SAR_CONV: begin
                if (!(hold_q >= vth)) begin
                    resolved[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    resolved[idx_q - 1'b1] = 1'b1;
                    trial_d = resolved;
                    idx_d   = idx_q - 1'b1;
                end else begin
                    trial_d = resolved;
                    state_d = SAR_DONE;
                    // Out-of-range samples still walk all bits; only the reported code is clamped.
                    dout_d  = lo_q ? '0 : (hi_q ? '1 : resolved);
                    ovr_d   = lo_q | hi_q;
                end
            end
            default: state_d = SAR_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= SAR_IDLE;
            hold_q  <= 0.0;
            trial_q <= '0;
            idx_q   <= '0;
            lo_q    <= 1'b0;
            hi_q    <= 1'b0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trial_q <= trial_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dout_q  <= dout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign BUSY = (state_q == SAR_CONV);
    assign DONE = (state_q == SAR_DONE);
    assign DOUT = dout_q;
    assign OVR  = ovr_q;

endmodule

// File: tb/tb_sar_adc_wr.sv
// tb/tb_sar_adc_wr.sv - randomized self-checking bench for sar_adc_wr against an arithmetic reference
`timescale 1ns/1ps
module tb_sar_adc_wr;
    import sar_pkg::*;

    localparam int  NB   = 8;
    localparam real VLO  = 0.0;
    localparam real VHI  = 1.0;
    localparam real LSB  = (VHI - VLO) / 256.0;
    localparam real PI   = 3.141592653589793;

    logic          clk;
    logic          rst_n;
    real           ain;
    logic          start;
    logic          busy;
    logic          done;
    logic [NB-1:0] dout;
    logic          ovr;

    int            checks;
    int            errors;
    logic [NB-1:0] prev_dout;
    logic          prev_ovr;

    sar_adc_wr #(
        .NBITS (NB),
        .VMIN  (VLO),
        .VREF  (VHI)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .AIN   (ain),
        .START (start),
        .BUSY  (busy),
        .DONE  (done),
        .DOUT  (dout),
        .OVR   (ovr)
    );

    initial clk = 1'b0;
    always #(SAR_CLK_PERIOD_NS / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void ref_model(input real v, output logic [NB-1:0] code, output logic o);
        if (v < VLO) begin
            code = '0;
            o    = 1'b1;
        end else if (v >= VHI) begin
            code = '1;
            o    = 1'b1;
        end else begin
            code = NB'(int'($floor((v - VLO) / LSB)));
            o    = 1'b0;
        end
    endfunction

    task automatic convert(input real v, input logic [NB-1:0] ec, input logic eo,
                           input bit disturb, input real dv);
        int lat;
        int busy_cnt;
        int hold_err;
        @(negedge clk);
        ain   = v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        hold_err = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (dout !== prev_dout || ovr !== prev_ovr) hold_err++;
            if (disturb) begin
                if (lat == 2) ain = dv;
                if (lat == 3) start = 1'b1;
                if (lat == 4) start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NB + 1);
        check("busy_cycles", busy_cnt, NB);
        check("dout", dout, ec);
        check("ovr", ovr, eo);
        check("busy_with_done", busy, 0);
        check("out_hold", hold_err, 0);
        prev_dout = ec;
        prev_ovr  = eo;
        @(negedge clk);
        check("done_width", done, 0);
        check("no_requeue", busy, 0);
    endtask

    task automatic back_to_back();
        real           vals[2];
        logic [NB-1:0] codes[2];
        int            gap;
        vals[0]  = 0.1;
        vals[1]  = 0.6;
        codes[0] = 8'h19;
        codes[1] = 8'h99;
        @(negedge clk);
        ain   = vals[0];
        start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (done !== 1'b1 && gap < 40);
            check("b2b_gap", gap, NB + 1);
            check("b2b_dout", dout, codes[n % 2]);
            ain = vals[(n + 1) % 2];
            if (n == 3) start = 1'b0;
        end
        @(negedge clk);
        check("b2b_stop", busy, 0);
        prev_dout = codes[1];
        prev_ovr  = 1'b0;
    endtask

    task automatic reset_abort();
        int dseen;
        @(negedge clk);
        ain   = 0.7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dout", dout, 0);
        check("abort_ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dseen++;
        end
        check("abort_no_done", dseen, 0);
        prev_dout = '0;
        prev_ovr  = 1'b0;
    endtask

    task automatic chain_test();
        real           a;
        real           y;
        logic [NB-1:0] ec;
        logic          eo;
        int            lat;
        a = 1.0 - $exp(-2.0 * PI * 10.0e6 * 1.0e-9);
        y = 0.0;
        @(posedge clk);
        #4;
        ain = 0.0;
        for (int k = 0; k < 16; k++) begin
            #0.5;
            y   = y + a * (1.0 - y);
            ain = y;
            if (k < 15) #0.5;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ain   = 1.0;
        ref_model(y, ec, eo);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("chain_done", done, 1);
        check("chain_dout", dout, ec);
        check("chain_window", (dout >= 8'd159 && dout <= 8'd163) ? 1 : 0, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        real           dv[7];
        logic [NB-1:0] dc[7];
        logic          dov[7];
        real           v;
        logic [NB-1:0] ec;
        logic          eo;

        checks    = 0;
        errors    = 0;
        prev_dout = '0;
        prev_ovr  = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        ain       = 0.0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1'b1;

        dv[0] = 0.5;         dc[0] = 8'h80; dov[0] = 1'b0;
        dv[1] = 0.3;         dc[1] = 8'h4C; dov[1] = 1'b0;
        dv[2] = 0.999;       dc[2] = 8'hFF; dov[2] = 1'b0;
        dv[3] = 1.0 / 256.0; dc[3] = 8'h01; dov[3] = 1'b0;
        dv[4] = 1.2;         dc[4] = 8'hFF; dov[4] = 1'b1;
        dv[5] = -0.1;        dc[5] = 8'h00; dov[5] = 1'b1;
        dv[6] = 0.25;        dc[6] = 8'h40; dov[6] = 1'b0;
        for (int i = 0; i < 7; i++) convert(dv[i], dc[i], dov[i], 1'b0, 0.0);

        convert(0.25, 8'h40, 1'b0, 1'b1, 0.9);
        back_to_back();
        reset_abort();
        convert(0.25, 8'h40, 1'b0, 1'b0, 0.0);

        for (int i = 0; i < 16; i++) begin
            v = real'($urandom_range(0, 14000)) / 10000.0 - 0.2;
            ref_model(v, ec, eo);
            convert(v, ec, eo, $urandom_range(0, 1) == 1,
                    real'($urandom_range(0, 10000)) / 10000.0);
        end

        chain_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
